// File: rtl/led_counter_ctrl_pkg.sv
// Shared types and helpers for the LED counter controller: repeat-FSM states,
// source indices and the millisecond-to-cycle conversion used by the timers.
package led_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int SRC_INC = 0;
    localparam int SRC_DEC = 1;
    localparam int NUM_SRC = 2;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Per-button hold-to-auto-repeat FSM: turns a debounced tick/level pair into
// a registered one-cycle event stream (press, hold expiry, then periodic repeats).
module btn_repeat
    import led_counter_ctrl_pkg::*;
#(
    parameter int HOLD_CYC = 5,
    parameter int RPT_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic evt
);

    localparam int TMR_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYC - 1);

    rpt_state_t       state_p0, state_nxt;
    logic [TMR_W-1:0] tmr_p0, tmr_nxt;
    logic             evt_nxt;

    // A fresh tick always wins: it emits and restarts the hold window.
    always_comb begin
        state_nxt = state_p0;
        tmr_nxt   = tmr_p0 + TMR_W'(1);
        evt_nxt   = 1'b0;
        case (state_p0)
            IDLE: begin
                tmr_nxt = '0;
                if (tick) begin
                    evt_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    evt_nxt = 1'b1;
                    tmr_nxt = '0;
                end else if (!level) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (tmr_p0 == HOLD_LAST) begin
                    evt_nxt   = 1'b1;
                    tmr_nxt   = '0;
                    state_nxt = REPEAT;
                end
            end
            REPEAT: begin
                if (tick) begin
                    evt_nxt   = 1'b1;
                    tmr_nxt   = '0;
                    state_nxt = HOLD;
                end else if (!level) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (tmr_p0 == RPT_LAST) begin
                    evt_nxt = 1'b1;
                    tmr_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            tmr_p0   <= '0;
            evt      <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            tmr_p0   <= tmr_nxt;
            evt      <= evt_nxt;
        end
    end

endmodule

// File: rtl/led_counter_ctrl.sv
// Up/down LED counter controller: per-button repeat FSMs feed small pending
// queues, a round-robin arbiter grants one counter update per cycle.
module led_counter_ctrl
    import led_counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int CLK_HZ   = 27_000_000,
    parameter int HOLD_MS  = 500,
    parameter int RPT_MS   = 100,
    parameter int WRAP     = 1,
    parameter int PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_tick,
    input  logic             inc_level,
    input  logic             dec_tick,
    input  logic             dec_level,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             ovf
);

    localparam int         HOLD_CYC  = ms_to_cycles(CLK_HZ, HOLD_MS);
    localparam int         RPT_CYC   = ms_to_cycles(CLK_HZ, RPT_MS);
    localparam logic [1:0] PEND_FULL = 2'(PEND_MAX);

    logic [NUM_SRC-1:0]      tick_v, level_v, evt_p0;
    logic [NUM_SRC-1:0][1:0] pend_p1, pend_nxt;
    logic [NUM_SRC-1:0]      gnt, drop;
    logic                    contended;
    logic                    rr_dec_p1;
    logic                    busy_p1, ovf_p1;
    logic [WIDTH-1:0]        cnt_p2;

    function automatic logic [WIDTH-1:0] step_cnt(input logic [WIDTH-1:0] cur, input logic up);
        if (up) begin
            if (WRAP == 0 && cur == {WIDTH{1'b1}}) return cur;
            return cur + WIDTH'(1);
        end
        if (WRAP == 0 && cur == '0) return cur;
        return cur - WIDTH'(1);
    endfunction

    assign tick_v[SRC_INC]  = inc_tick;
    assign tick_v[SRC_DEC]  = dec_tick;
    assign level_v[SRC_INC] = inc_level;
    assign level_v[SRC_DEC] = dec_level;

    // Stage p0: registered button events
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        btn_repeat #(
            .HOLD_CYC (HOLD_CYC),
            .RPT_CYC  (RPT_CYC)
        ) u_rpt (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick_v[s]),
            .level (level_v[s]),
            .evt   (evt_p0[s])
        );
    end

    // Arbitration reads only the registered pending counts; the pointer moves
    // only when both sources compete.
    always_comb begin
        gnt       = '0;
        contended = (pend_p1[SRC_INC] != 2'd0) && (pend_p1[SRC_DEC] != 2'd0);
        if (contended) begin
            if (rr_dec_p1) gnt[SRC_DEC] = 1'b1;
            else           gnt[SRC_INC] = 1'b1;
        end else if (pend_p1[SRC_INC] != 2'd0) begin
            gnt[SRC_INC] = 1'b1;
        end else if (pend_p1[SRC_DEC] != 2'd0) begin
            gnt[SRC_DEC] = 1'b1;
        end
    end

    always_comb begin
        pend_nxt = pend_p1;
        drop     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (evt_p0[s] && !gnt[s]) begin
                if (pend_p1[s] == PEND_FULL) drop[s] = 1'b1;
                else                         pend_nxt[s] = pend_p1[s] + 2'd1;
            end else if (!evt_p0[s] && gnt[s]) begin
                pend_nxt[s] = pend_p1[s] - 2'd1;
            end
        end
    end

    // Stage p1: pending queues / status, stage p2: counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p1   <= '0;
            busy_p1   <= 1'b0;
            ovf_p1    <= 1'b0;
            rr_dec_p1 <= 1'b0;
            cnt_p2    <= '0;
        end else if (clr) begin
            pend_p1 <= '0;
            busy_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            cnt_p2  <= '0;
        end else begin
            pend_p1 <= pend_nxt;
            busy_p1 <= |pend_nxt;
            ovf_p1  <= ovf_p1 | (|drop);
            if (contended) rr_dec_p1 <= gnt[SRC_INC];
            if (gnt[SRC_INC])      cnt_p2 <= step_cnt(cnt_p2, 1'b1);
            else if (gnt[SRC_DEC]) cnt_p2 <= step_cnt(cnt_p2, 1'b0);
        end
    end

    assign cnt  = cnt_p2;
    assign led  = ~cnt_p2;
    assign busy = busy_p1;
    assign ovf  = ovf_p1;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Bench for led_counter_ctrl: per-cycle vector table through a scoreboard queue,
// plus a long hold sequence that drives the saturating instance to its top bound.
module tb_led_counter_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inc_tick = 1'b0, inc_level = 1'b0, dec_tick = 1'b0, dec_level = 1'b0, clr = 1'b0;
    logic [W-1:0] cnt, led, cnt_s, led_s;
    logic         busy, ovf, busy_s, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_counter_ctrl #(
        .WIDTH(W), .CLK_HZ(1000), .HOLD_MS(5), .RPT_MS(2), .WRAP(1), .PEND_MAX(3)
    ) dut (
        .clk(clk), .rst(rst), .inc_tick(inc_tick), .inc_level(inc_level),
        .dec_tick(dec_tick), .dec_level(dec_level), .clr(clr),
        .cnt(cnt), .led(led), .busy(busy), .ovf(ovf)
    );

    led_counter_ctrl #(
        .WIDTH(W), .CLK_HZ(1000), .HOLD_MS(5), .RPT_MS(2), .WRAP(0), .PEND_MAX(3)
    ) dut_sat (
        .clk(clk), .rst(rst), .inc_tick(inc_tick), .inc_level(inc_level),
        .dec_tick(dec_tick), .dec_level(dec_level), .clr(clr),
        .cnt(cnt_s), .led(led_s), .busy(busy_s), .ovf(ovf_s)
    );

    typedef struct {
        logic r, it, il, dt, dl, c;
        int   cnt, cnt_s;
        logic busy, ovf;
    } vec_t;

    typedef struct {
        int   row;
        int   cnt, cnt_s;
        logic busy, ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, it, il, dt, dl, c,
                       input int ec, ecs, input logic eb, eo);
        vec_t v;
        v.r = r; v.it = it; v.il = il; v.dt = dt; v.dl = dl; v.c = c;
        v.cnt = ec; v.cnt_s = ecs; v.busy = eb; v.ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, it, il, dt, dl, c);
        @(negedge clk);
        rst = r; inc_tick = it; inc_level = il; dec_tick = dt; dec_level = dl; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k4_cnt[18]  = '{0,0,1,1,1,1,1,2,2,3,3,4,4,5,5,6,6,6};
        int k4_busy[18] = '{0,1,0,0,0,0,1,0,1,0,1,0,1,0,1,0,0,0};
        int j5_cnt[9]   = '{6,6,7,6,7,6,7,0,0};
        int j5_busy[9]  = '{0,1,1,1,1,1,1,0,0};
        int j5_ovf[9]   = '{0,0,0,0,0,0,1,0,0};
        int k6_cnt[20]  = '{0,0,1,1,1,1,1,2,2,3,0,0,0,0,0,0,0,0,1,1};
        int k6_busy[20] = '{0,1,0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,1,0,0};

        // Reset, idle, then a single increment
        add(1,0,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 9; i++) add(0,0,0,0,0,0, 0,0,0,0);
        add(0,1,1,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        // Back-to-back increments up to 5
        add(0,1,1,0,0,0, 1,1,0,0);
        add(0,1,1,0,0,0, 1,1,1,0);
        add(0,1,1,0,0,0, 2,2,1,0);
        add(0,1,1,0,0,0, 3,3,1,0);
        add(0,0,0,0,0,0, 4,4,1,0);
        add(0,0,0,0,0,0, 5,5,0,0);
        add(0,0,0,0,0,0, 5,5,0,0);
        // Simultaneous presses: inc wins first, dec follows
        add(0,1,1,1,1,0, 5,5,0,0);
        add(0,0,0,0,0,0, 5,5,1,0);
        add(0,0,0,0,0,0, 6,6,1,0);
        add(0,0,0,0,0,0, 5,5,0,0);
        add(0,0,0,0,0,0, 5,5,0,0);
        // Decrement below zero: wraps on one instance, clamps on the other
        add(1,0,0,0,0,0, 0,0,0,0);
        add(0,0,0,1,1,0, 0,0,0,0);
        add(0,0,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0,0, 63,0,0,0);
        add(0,0,0,0,0,0, 63,0,0,0);
        // Hold-to-repeat for 14 cycles
        add(1,0,0,0,0,0, 0,0,0,0);
        for (int k = 0; k < 18; k++)
            add(0, k == 0, k <= 13, 0, 0, 0, k4_cnt[k], k4_cnt[k], k4_busy[k][0], 1'b0);
        // Contention until both queues fill, then clear
        for (int j = 0; j < 9; j++)
            add(0, j <= 5, j <= 5, j <= 5, j <= 5, j == 7,
                j5_cnt[j], j5_cnt[j], j5_busy[j][0], j5_ovf[j][0]);
        // Reset mid-repeat with the level still held
        for (int k = 0; k < 20; k++)
            add(k == 10, k == 0 || k == 16, k <= 18, 0, 0, 0,
                k6_cnt[k], k6_cnt[k], k6_busy[k][0], 1'b0);

        foreach (vecs[i]) begin
            exp_t e;
            @(negedge clk);
            rst = vecs[i].r; inc_tick = vecs[i].it; inc_level = vecs[i].il;
            dec_tick = vecs[i].dt; dec_level = vecs[i].dl; clr = vecs[i].c;
            e.row = i; e.cnt = vecs[i].cnt; e.cnt_s = vecs[i].cnt_s;
            e.busy = vecs[i].busy; e.ovf = vecs[i].ovf;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("cnt",   e.row, int'(cnt),   e.cnt);
            check("led",   e.row, int'(led),   63 - e.cnt);
            check("busy",  e.row, int'(busy),  int'(e.busy));
            check("ovf",   e.row, int'(ovf),   int'(e.ovf));
            check("cnt_s", e.row, int'(cnt_s), e.cnt_s);
        end

        // Long hold: 69 events, wrapping instance ends at 69 mod 64, clamp at 63
        drive(1,0,0,0,0,0);
        drive(0,1,1,0,0,0);
        for (int i = 0; i < 139; i++) drive(0,0,1,0,0,0);
        for (int i = 0; i < 5; i++) drive(0,0,0,0,0,0);
        check("hold_cnt_s",  1000, int'(cnt_s),  63);
        check("hold_led_s",  1000, int'(led_s),  0);
        check("hold_cnt",    1000, int'(cnt),    5);
        check("hold_busy_s", 1000, int'(busy_s), 0);
        check("hold_busy",   1000, int'(busy),   0);
        // One more increment at the top bound is consumed without moving cnt
        drive(0,1,0,0,0,0);
        drive(0,0,0,0,0,0);
        check("top_busy_s1", 1001, int'(busy_s), 1);
        drive(0,0,0,0,0,0);
        check("top_cnt_s",   1002, int'(cnt_s),  63);
        check("top_busy_s0", 1002, int'(busy_s), 0);
        check("top_ovf_s",   1002, int'(ovf_s),  0);
        check("top_cnt",     1002, int'(cnt),    6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
